// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared types and constants for the mem_copy_master block.
package mem_copy_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  BE_ALL     = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_FIN     = 3'd5
  } mem_copy_state_e;

  // Clear the byte-offset bits of a byte address.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/mem_copy_wdog.sv
// mem_copy_wdog: loadable down-counter that flags a stalled bus phase.
// Reloads while cleared or disabled; o_expire fires on the WDOG_CYCLES-th
// enabled cycle. WDOG_CYCLES == 0 disables the watchdog entirely.
module mem_copy_wdog #(
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  // Count down the cycles spent in one phase; reload on every phase change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en) begin
      r_cnt <= CW'(WDOG_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire = (WDOG_CYCLES != 0) && i_en && (r_cnt == CW'(1));

endmodule

// File: rtl/mem_copy_master.sv
// mem_copy_master: single-outstanding req/gnt/rvalid initiator that copies
// len_i words from src to dst. Optional MEM_COPY_FILL_EN adds a fill mode
// (write fill_data_i to every destination word, no reads).
// Handshake: a request is held (req, addr, we, wdata stable) until gnt is
// sampled high; its response is the first rvalid seen in the matching WAIT
// state, and rvalid anywhere else is ignored.
module mem_copy_master
  import mem_copy_pkg::*;
#(
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned WDOG_CYCLES = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
`ifdef MEM_COPY_FILL_EN
  input  logic                 fill_i,
  input  logic [31:0]          fill_data_i,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 port_req_o,
  input  logic                 port_gnt_i,
  input  logic                 port_rvalid_i,
  output logic [31:0]          port_addr_o,
  output logic                 port_we_o,
  output logic [3:0]           port_be_o,
  output logic [31:0]          port_wdata_o,
  input  logic [31:0]          port_rdata_i,
  input  logic                 port_err_i,
  output mem_copy_state_e      dbg_state_o
);

  mem_copy_state_e      r_state, w_state_next;
  logic [31:0]          r_src, r_dst, r_data;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic                 r_err, r_done;
  logic                 w_accept, w_abort, w_wdog_en, w_wdog_expire;
  logic                 w_fill_mode, w_start_fill;

`ifdef MEM_COPY_FILL_EN
  logic r_fill;
  assign w_fill_mode  = r_fill;
  assign w_start_fill = fill_i;
`else
  assign w_fill_mode  = 1'b0;
  assign w_start_fill = 1'b0;
`endif

  assign w_accept  = (r_state == ST_IDLE) && start_i;
  assign w_wdog_en = (r_state == ST_RD_REQ) || (r_state == ST_RD_WAIT) ||
                     (r_state == ST_WR_REQ) || (r_state == ST_WR_WAIT);

  mem_copy_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .i_clr    (w_state_next != r_state),
    .i_en     (w_wdog_en),
    .o_expire (w_wdog_expire)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // Next state; a bus event in the expiry cycle wins over the watchdog.
  always_comb begin
    w_state_next = r_state;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i == '0)       w_state_next = ST_FIN;
          else if (w_start_fill) w_state_next = ST_WR_REQ;
          else                   w_state_next = ST_RD_REQ;
        end
      end
      ST_RD_REQ, ST_WR_REQ: begin
        if (port_gnt_i)
          w_state_next = (r_state == ST_RD_REQ) ? ST_RD_WAIT : ST_WR_WAIT;
        else if (w_wdog_expire) begin
          w_state_next = ST_FIN;
          w_abort      = 1'b1;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (port_rvalid_i) begin
          if (port_err_i) begin
            w_state_next = ST_FIN;
            w_abort      = 1'b1;
          end else if (r_state == ST_RD_WAIT) begin
            w_state_next = ST_WR_REQ;
          end else if (r_remaining == LEN_WIDTH'(1)) begin
            w_state_next = ST_FIN;
          end else begin
            w_state_next = w_fill_mode ? ST_WR_REQ : ST_RD_REQ;
          end
        end else if (w_wdog_expire) begin
          w_state_next = ST_FIN;
          w_abort      = 1'b1;
        end
      end
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: latch the job at start, capture read data, advance per word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_data      <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
`ifdef MEM_COPY_FILL_EN
      r_fill      <= 1'b0;
`endif
    end else begin
      r_done <= (r_state == ST_FIN);
      if (w_accept) begin
        r_src       <= word_align(src_addr_i);
        r_dst       <= word_align(dst_addr_i);
        r_remaining <= len_i;
        r_err       <= 1'b0;
`ifdef MEM_COPY_FILL_EN
        r_fill      <= fill_i;
        r_data      <= fill_data_i;
`endif
      end else if (w_abort) begin
        r_err <= 1'b1;
      end else if (port_rvalid_i && (r_state == ST_RD_WAIT)) begin
        r_data <= port_rdata_i;
      end else if (port_rvalid_i && (r_state == ST_WR_WAIT)) begin
        r_src       <= r_src + 32'(WORD_BYTES);
        r_dst       <= r_dst + 32'(WORD_BYTES);
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
    end
  end

  assign port_req_o   = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
  assign port_we_o    = (r_state == ST_WR_REQ);
  assign port_addr_o  = (r_state == ST_RD_REQ) ? r_src :
                        (r_state == ST_WR_REQ) ? r_dst : 32'h0;
  assign port_be_o    = BE_ALL;
  assign port_wdata_o = r_data;
  assign busy_o       = w_wdog_en;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master: directed vector table plus hand sequences for the
// watchdog, mid-copy reset and (when MEM_COPY_FILL_EN is defined) fill mode.
module tb_mem_copy_master;
  import mem_copy_pkg::*;

  localparam int LW = 16;
  localparam int WD = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start;
  logic [31:0] src_addr, dst_addr, rdata, addr, wdata;
  logic [LW-1:0] len;
  logic gnt, rvalid, perr, busy, done, err, req, we;
  logic [3:0] be;
  mem_copy_state_e dbg_state;
`ifdef MEM_COPY_FILL_EN
  logic fill = 1'b0;
  logic [31:0] fill_data = 32'h0;
`endif

  mem_copy_master #(.LEN_WIDTH(LW), .WDOG_CYCLES(WD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .src_addr_i(src_addr), .dst_addr_i(dst_addr), .len_i(len),
`ifdef MEM_COPY_FILL_EN
    .fill_i(fill), .fill_data_i(fill_data),
`endif
    .busy_o(busy), .done_o(done), .err_o(err),
    .port_req_o(req), .port_gnt_i(gnt), .port_rvalid_i(rvalid),
    .port_addr_o(addr), .port_we_o(we), .port_be_o(be),
    .port_wdata_o(wdata), .port_rdata_i(rdata), .port_err_i(perr),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- sp_ram-style responder ----------------
  logic [31:0] mem [0:1023];
  int gnt_delay = 0, rv_delay = 0, err_rd_idx = 0, err_wr_idx = 0;
  int n_reads = 0, n_writes = 0;
  bit gnt_en = 1'b1;
  bit pending = 1'b0;
  int rv_cnt = 0, wait_cnt = 0;
  logic [31:0] cap_addr, cap_wdata, resp_data;
  logic cap_we, resp_err;

  initial begin
    gnt = 0; rvalid = 0; rdata = 0; perr = 0;
    forever begin
      @(negedge clk);
      gnt = 0; rvalid = 0; perr = 0;
      if (pending) begin
        chk("one_outstanding", 64'(req), 64'(0));
        if (rv_cnt == 0) begin
          rvalid = 1; rdata = resp_data; perr = resp_err; pending = 0;
        end else rv_cnt--;
      end else if (req) begin
        if (wait_cnt == 0) begin
          cap_addr = addr; cap_we = we; cap_wdata = wdata;
        end else begin
          chk("stall_addr_stable", 64'(addr), 64'(cap_addr));
          chk("stall_we_stable", 64'(we), 64'(cap_we));
          if (we) chk("stall_wdata_stable", 64'(wdata), 64'(cap_wdata));
        end
        if (gnt_en && wait_cnt >= gnt_delay) begin
          gnt = 1; wait_cnt = 0;
          chk("req_be", 64'(be), 64'(4'hF));
          chk("req_addr_aligned", 64'(addr[1:0]), 64'(0));
          if (!we) begin
            n_reads++;
            resp_data = mem[addr[11:2]];
            resp_err  = (n_reads == err_rd_idx);
          end else begin
            n_writes++;
            mem[addr[11:2]] = wdata;
            resp_err = (n_writes == err_wr_idx);
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_write: got write to 0x%08h, required none", addr);
            end else chk("write_addr_data", {addr, wdata}, exp_q.pop_front());
          end
          pending = 1; rv_cnt = rv_delay;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] src, dst;
    int len, gd, rd, err_rd, err_wr;
    bit fill;
    int exp_done, exp_err, exp_writes, exp_reads;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] exp_word(input vec_t v, input int k);
    logic [31:0] idx;
    idx = ((v.src >> 2) + 32'(k)) & 32'h3FF;
    return v.fill ? 32'hDEADBEEF : (32'hC0DE0000 | idx);
  endfunction

  // Run one copy from a start pulse and compare against the vector record.
  task automatic do_vec(input vec_t v, input string tag);
    int done_cyc;
    bit busy1, busy_done, err1, err_done, seen_busy;
    logic [31:0] didx;
    didx = v.dst >> 2;
    done_cyc = -1; busy1 = 0; busy_done = 1; err1 = 1; err_done = 0; seen_busy = 0;
    @(negedge clk);
    gnt_delay = v.gd; rv_delay = v.rd; err_rd_idx = v.err_rd; err_wr_idx = v.err_wr;
    n_reads = 0; n_writes = 0;
    exp_q.delete();
    for (int k = 0; k <= v.len; k++) mem[(didx + 32'(k)) & 32'h3FF] = 32'h0;
    for (int k = 0; k < v.exp_writes; k++)
      exp_q.push_back({(v.dst & ~32'h3) + 32'(4 * k), exp_word(v, k)});
`ifdef MEM_COPY_FILL_EN
    fill = v.fill; fill_data = 32'hDEADBEEF;
`endif
    start = 1; src_addr = v.src; dst_addr = v.dst; len = LW'(v.len);
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 0; busy1 = busy; err1 = err; end
      if (busy) seen_busy = 1;
      if (done) begin done_cyc = c; busy_done = busy; err_done = err; break; end
    end
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
    chk({tag, "_err_cleared_at_start"}, 64'(err1), 64'(0));
    chk({tag, "_err_at_done"}, 64'(err_done), 64'(v.exp_err));
    chk({tag, "_busy_cycle1"}, 64'(busy1), 64'(v.len != 0));
    chk({tag, "_busy_seen"}, 64'(seen_busy), 64'(v.len != 0));
    chk({tag, "_busy_at_done"}, 64'(busy_done), 64'(0));
    chk({tag, "_n_writes"}, 64'(n_writes), 64'(v.exp_writes));
    chk({tag, "_n_reads"}, 64'(n_reads), 64'(v.exp_reads));
    chk({tag, "_exp_q_drained"}, 64'(exp_q.size()), 64'(0));
    for (int k = 0; k < v.exp_writes; k++)
      chk({tag, "_mem_word"}, 64'(mem[(didx + 32'(k)) & 32'h3FF]), 64'(exp_word(v, k)));
    chk({tag, "_mem_past_end"}, 64'(mem[(didx + 32'(v.exp_writes)) & 32'h3FF]), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int done_cyc;
    bit req8, req9, bad;
    start = 0; src_addr = 0; dst_addr = 0; len = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);

    //           src           dst       len gd rd erd ewr fill done err w  r
    vecs[0] = '{32'h100,      32'h200, 4, 0, 0, 0, 0, 0, 18, 0, 4, 4};
    vecs[1] = '{32'h140,      32'h240, 3, 3, 2, 0, 0, 0, 44, 0, 3, 3};
    vecs[2] = '{32'h100,      32'h280, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0};
    vecs[3] = '{32'h100,      32'h2C0, 4, 0, 0, 2, 0, 0,  8, 1, 1, 2};
    vecs[4] = '{32'h103,      32'h301, 2, 1, 0, 0, 0, 0, 14, 0, 2, 2};
    vecs[5] = '{32'hFFFFFFF8, 32'h340, 3, 0, 1, 0, 0, 0, 20, 0, 3, 3};
    vecs[6] = '{32'h120,      32'h380, 3, 0, 0, 0, 2, 0, 10, 1, 2, 2};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_vec(vecs[i], $sformatf("v%0d", i));

    // Watchdog: no grant ever; a second start mid-copy must be ignored.
    @(negedge clk);
    gnt_en = 0; err_rd_idx = 0; err_wr_idx = 0; n_reads = 0; n_writes = 0;
    exp_q.delete();
    done_cyc = -1; req8 = 0; req9 = 1;
    start = 1; src_addr = 32'h100; dst_addr = 32'h380; len = LW'(2);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) start = 0;
      if (c == 3) begin start = 1; len = '0; end
      if (c == 4) start = 0;
      if (c == 8) req8 = req;
      if (c == 9) req9 = req;
      if (done) begin done_cyc = c; break; end
    end
    chk("wdog_req_cycle8", 64'(req8), 64'(1));
    chk("wdog_req_dropped", 64'(req9), 64'(0));
    chk("wdog_done_cycle", 64'(done_cyc), 64'(10));
    chk("wdog_err", 64'(err), 64'(1));
    chk("wdog_n_reads", 64'(n_reads), 64'(0));
    repeat (4) @(negedge clk);
    chk("wdog_idle_after", 64'(dbg_state), 64'(ST_IDLE));
    chk("wdog_err_sticky", 64'(err), 64'(1));
    gnt_en = 1;

    // Reset while requesting: req drops without a clock edge.
    @(negedge clk);
    gnt_delay = 6; rv_delay = 0;
    start = 1; src_addr = 32'h100; dst_addr = 32'h3C0; len = LW'(2);
    @(negedge clk); start = 0;
    @(negedge clk);
    chk("rstA_req_before", 64'(req), 64'(1));
    #2 rst_n = 0;
    #1 chk("rstA_req_async_drop", 64'(req), 64'(0));
    chk("rstA_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rstA_err", 64'(err), 64'(0));
    @(negedge clk); rst_n = 1;

    // Reset while a read is outstanding: the late rvalid is ignored.
    @(negedge clk);
    gnt_delay = 0; rv_delay = 6;
    start = 1; src_addr = 32'h100; dst_addr = 32'h3C0; len = LW'(2);
    @(negedge clk); start = 0;
    @(negedge clk);
    chk("rstB_in_rd_wait", 64'(dbg_state), 64'(ST_RD_WAIT));
    #2 rst_n = 0;
    @(negedge clk); rst_n = 1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || req || busy || dbg_state != ST_IDLE) bad = 1;
    end
    chk("rstB_late_rvalid_ignored", 64'(bad), 64'(0));
    rv_delay = 0;

`ifdef MEM_COPY_FILL_EN
    begin
      vec_t fv;
      fv = '{32'h0, 32'h0, 3, 0, 0, 0, 0, 1, 8, 0, 3, 0};
      do_vec(fv, "fill");
    end
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
